mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Parametrised N-requester arbiter that multiplexes several masters onto one synchronous BRAM port. Typical masters are the C2 loader, core fetch/LSU and the dumper. It generalises the fixed loader-over-core port glue with:
- configurable requester count, data width and byte-enable width;
- fixed-priority or round-robin arbitration;
- a lock for burst ownership;
- tagged read-return routing across a configurable memory read latency.

It sits between the masters and each `risky_access_memory` port in the FPGA top.

## Interface
- `N_REQ`, 2: number of requesters; index 0 is highest priority in fixed mode.
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data width; `BE_W = DATA_W/8`.
- `ARB_MODE`, `ARB_FIXED`: `ARB_FIXED` or `ARB_RR` (enum from package).
- `RD_LAT`, 1: memory read latency in cycles, 1..3.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_i` in `N_REQ`: per-requester access request.
- `lock_i` in `N_REQ`: request to keep ownership after the current grant.
- `be_i` in `N_REQ*BE_W`: byte write mask; all-zero means read.
- `addr_i` in `N_REQ*ADDR_W`: byte address per requester.
- `wdata_i` in `N_REQ*DATA_W`: write data per requester.
- `gnt_o` out `N_REQ`: one-hot grant, combinational, same cycle.
- `rvalid_o` out `N_REQ`: read data valid for that requester.
- `rdata_o` out `DATA_W`: read data, shared by all requesters.
- `mem_en_o` out 1: memory port enable.
- `mem_we_o` out `BE_W`: memory byte write enable.
- `mem_addr_o` out `ADDR_W`: byte address, forwarded unchanged.
- `mem_wdata_o` out `DATA_W`: memory write data.
- `mem_rdata_i` in `DATA_W`: memory read data.

## Operation
- Grant is combinational from `req_i`, `rr_ptr_q` and lock state. At most one bit of `gnt_o` is set. `gnt_o` is 0 when no request is eligible.
- The granted requester's `be_i`, `addr_i` and `wdata_i` drive the `mem_*` outputs.
  - `mem_en_o` equals `|gnt_o`.
  - When nothing is granted, all `mem_*` outputs are 0.
- Fixed mode: the lowest asserted index wins.
- Round-robin mode:
  - Search starts at `rr_ptr_q`, wrapping from `N_REQ-1` to 0.
  - On any grant to k, `rr_ptr_q` becomes `(k+1) mod N_REQ`.
  - `rr_ptr_q` is unchanged when nothing is granted.
- Lock:
  - At a clock edge where `gnt_o[k]` and `lock_i[k]` are both high, `lock_vld_q` is set to 1 and `lock_own_q` to k.
  - While `lock_vld_q` is set, only the owner is eligible. Other requesters stall even if the owner is idle.
  - The lock clears at the first edge where `lock_i[lock_own_q]` is 0, whether or not the owner is requesting.
  - Round-robin `rr_ptr_q` advances normally during a lock.
- Read tagging: a granted read (`be_i` == 0) pushes `{valid=1, id=k}` into an `RD_LAT`-deep shift register. Writes and idle cycles push `valid=0`.
- Return path: at the register output, `rvalid_o[id]` = valid and `rdata_o` = `mem_rdata_i`.
  - `rdata_o` is a pure pass-through and is don't-care when no `rvalid_o` bit is set.
- Requesters must hold `req_i` and payload stable until granted. A request dropped before grant is legal and is simply lost.

## Timing
- Reset values (asynchronous, on `rst_i`): `rr_ptr_q`=0, `lock_vld_q`=0, `lock_own_q`=0, tag pipeline cleared.
  - `rvalid_o`=0 during reset and for `RD_LAT` cycles after release.
  - `gnt_o` and `mem_*` follow their inputs combinationally but are forced to 0 while `rst_i`=1.
- Grant latency: 0 cycles. The access is issued on the edge ending the grant cycle.
- Read data: `rvalid_o` rises exactly `RD_LAT` cycles after the grant edge. With back-to-back reads there is one return per cycle, in issue order.
- Simultaneous lock and release: if the owner deasserts `lock_i` while still granted, that grant completes and the lock clears at the same edge.
- Reset mid-lock or mid-read: the lock is dropped, in-flight reads are discarded, and no `rvalid_o` is produced for them.
- `N_REQ`=1: always granted when `req_i[0]` is high. Lock has no effect.

## Structure
- `mem_arb_pkg` contains:
  - `arb_mode_e` {`ARB_FIXED`, `ARB_RR`};
  - `rd_tag_t` (valid plus an id of `$clog2(N_REQ)` bits, minimum 1 bit);
  - a `MAX_RD_LAT` constant of 3.
- One sub-module: `rr_priority_picker`, a parametric rotate-and-find-first one-hot picker taking a start index. Fixed mode uses start index 0.
- The tag shift register and lock registers live in `mem_port_arbiter`.

## Test plan
- Fixed mode, `N_REQ`=2, `RD_LAT`=1: `req_i`=2'b11, requester 0 writes `be`=4'hF `addr`=0x10 `wdata`=0xDEADBEEF, requester 1 reads 0x10. Required response:
  - `gnt_o`=01, then 10 the next cycle;
  - requester 1 sees `rvalid_o[1]`=1 with `rdata_o`=0xDEADBEEF one cycle after its grant.
- Round-robin mode, `N_REQ`=3, all requesting for 6 cycles: `gnt_o` sequence is 001, 010, 100, 001, 010, 100.
- Lock: requester 1 holds `lock_i` for 4 grants while requester 0 requests continuously. Required response:
  - `gnt_o[0]` stays 0 until the edge after `lock_i[1]` falls;
  - `gnt_o[0]` then rises the next cycle.
- `RD_LAT`=2, alternating reads from requesters 0 and 1 at addresses 0x0 and 0x4 (preloaded 0x11111111 and 0x22222222): `rvalid_o` follows the same alternating order 2 cycles after each grant with the matching data.
- Byte write: `be`=4'b0100, `wdata`=0x00AB0000 to 0x8 (preloaded 0). A subsequent read returns 0x00AB0000, and `mem_we_o` showed 4'b0100 during the write.
- Assert `rst_i` one cycle after a granted read with a lock held. Required response:
  - no `rvalid_o`;
  - `lock_vld_q`=0;
  - after release, fixed mode grants requester 0 first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  // Arbitration policy selector.
  typedef enum logic [0:0] {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Deepest supported memory read latency.
  localparam int MAX_RD_LAT = 3;

  // The tag id field is sized for up to 2**MAX_ID_W requesters. The
  // arbiter only ever uses the low idWidth(N_REQ) bits.
  localparam int MAX_ID_W = 4;

  // One slot of the read-return tag pipeline.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } rd_tag_t;

  // Bits needed to index n requesters, never less than one.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotate-and-find-first one-hot picker. The search begins at i_start and
// wraps from N-1 back to 0; a start of 0 gives plain fixed priority.
module rr_priority_picker
  import mem_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_gnt,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Two passes: first the indices at or above the start, then the wrapped
  // indices below it, keeping only the first hit.
  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    for (int j = 0; j < N; j++) begin
      if (!o_valid && (j >= int'(i_start)) && i_req[j]) begin
        o_valid  = 1'b1;
        o_idx    = IDX_W'(j);
        o_gnt[j] = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!o_valid && (j < int'(i_start)) && i_req[j]) begin
        o_valid  = 1'b1;
        o_idx    = IDX_W'(j);
        o_gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-requester arbiter multiplexing masters onto one synchronous BRAM port,
// with fixed or round-robin priority, burst lock and tagged read returns.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int        N_REQ    = 2,
  parameter int        ADDR_W   = 32,
  parameter int        DATA_W   = 32,
  parameter arb_mode_e ARB_MODE = ARB_FIXED,
  parameter int        RD_LAT   = 1,
  localparam int       BE_W     = DATA_W / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         lock_i,
  input  logic [N_REQ*BE_W-1:0]    be_i,
  input  logic [N_REQ*ADDR_W-1:0]  addr_i,
  input  logic [N_REQ*DATA_W-1:0]  wdata_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [N_REQ-1:0]         rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     mem_en_o,
  output logic [BE_W-1:0]          mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic [DATA_W-1:0]        mem_rdata_i
);

  localparam int ID_W = idWidth(N_REQ);

  // RD_LAT is expected to lie in 1..MAX_RD_LAT.

  logic [ID_W-1:0]   r_rrPtr;
  logic              r_lockVld;
  logic [ID_W-1:0]   r_lockOwn;
  rd_tag_t           r_tagPipe [RD_LAT];

  logic [N_REQ-1:0]  w_ownerMask;
  logic [N_REQ-1:0]  w_eligible;
  logic [ID_W-1:0]   w_start;
  logic [N_REQ-1:0]  w_pickGnt;
  logic              w_pickVld;
  logic [ID_W-1:0]   w_pickIdx;
  logic [N_REQ-1:0]  w_gnt;
  logic              w_gntVld;
  logic              w_ownerLock;
  logic              w_gntLock;
  logic              w_isRead;
  logic [BE_W-1:0]   w_be;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  rd_tag_t           w_tagOut;

  // While a lock is held only the owner may compete; everyone else stalls
  // even when the owner is idle.
  always_comb begin
    w_ownerMask = '0;
    for (int j = 0; j < N_REQ; j++) begin
      w_ownerMask[j] = (r_lockOwn == ID_W'(j));
    end
    w_eligible  = r_lockVld ? (req_i & w_ownerMask) : req_i;
    w_ownerLock = |(lock_i & w_ownerMask);
  end

  assign w_start = (ARB_MODE == ARB_RR) ? r_rrPtr : '0;

  rr_priority_picker #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_picker (
    .i_req   (w_eligible),
    .i_start (w_start),
    .o_gnt   (w_pickGnt),
    .o_valid (w_pickVld),
    .o_idx   (w_pickIdx)
  );

  assign w_gnt     = rst_i ? '0 : w_pickGnt;
  assign w_gntVld  = !rst_i && w_pickVld;
  assign w_gntLock = |(lock_i & w_gnt);

  // Steer the granted requester's payload onto the memory port; an empty
  // grant leaves every memory output at zero.
  always_comb begin
    w_be    = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_gnt[j]) begin
        w_be    = be_i[j*BE_W +: BE_W];
        w_addr  = addr_i[j*ADDR_W +: ADDR_W];
        w_wdata = wdata_i[j*DATA_W +: DATA_W];
      end
    end
  end

  assign w_isRead    = w_gntVld && (w_be == '0);
  assign gnt_o       = w_gnt;
  assign mem_en_o    = w_gntVld;
  assign mem_we_o    = w_be;
  assign mem_addr_o  = w_addr;
  assign mem_wdata_o = w_wdata;

  // Round-robin pointer moves just past whoever was granted, locked or not.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rrPtr <= '0;
    end else if (w_gntVld) begin
      r_rrPtr <= (w_pickIdx == ID_W'(N_REQ - 1)) ? '0 : (w_pickIdx + ID_W'(1));
    end
  end

  if (N_REQ > 1) begin : g_lock
    // Lock is taken by a granted requester asserting lock_i and dropped at
    // the first edge the owner's lock_i is low, requesting or not.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_lockVld <= 1'b0;
        r_lockOwn <= '0;
      end else if (r_lockVld) begin
        if (!w_ownerLock) begin
          r_lockVld <= 1'b0;
        end
      end else if (w_gntLock) begin
        r_lockVld <= 1'b1;
        r_lockOwn <= w_pickIdx;
      end
    end
  end else begin : g_noLock
    assign r_lockVld = 1'b0;
    assign r_lockOwn = '0;
  end

  // Tag pipeline tracks which requester owns each in-flight read so the
  // return lines up with the memory's read latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < RD_LAT; s++) begin
        r_tagPipe[s] <= '0;
      end
    end else begin
      r_tagPipe[0] <= rd_tag_t'{valid: w_isRead, id: MAX_ID_W'(w_pickIdx)};
      for (int s = 1; s < RD_LAT; s++) begin
        r_tagPipe[s] <= r_tagPipe[s-1];
      end
    end
  end

  assign w_tagOut = r_tagPipe[RD_LAT-1];

  // Decode the tag leaving the pipeline into the per-requester valid.
  always_comb begin
    rvalid_o = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (w_tagOut.valid && (w_tagOut.id == MAX_ID_W'(j))) begin
        rvalid_o[j] = 1'b1;
      end
    end
  end

  assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench: a fixed-priority RD_LAT=1 arbiter and a
// round-robin RD_LAT=2 arbiter share stimulus, each against its own BRAM.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req   = '0;
  logic [N-1:0]    lock  = '0;
  logic [N*BW-1:0] be    = '0;
  logic [N*AW-1:0] addr  = '0;
  logic [N*DW-1:0] wdata = '0;

  logic [N-1:0]  gnt      [2];
  logic [N-1:0]  rvalid   [2];
  logic [DW-1:0] rdata    [2];
  logic          memEn    [2];
  logic [BW-1:0] memWe    [2];
  logic [AW-1:0] memAddr  [2];
  logic [DW-1:0] memWdata [2];
  logic [DW-1:0] memRdata [2];

  mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(ARB_FIXED), .RD_LAT(1)) u_fixed (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .mem_en_o(memEn[0]), .mem_we_o(memWe[0]),
    .mem_addr_o(memAddr[0]), .mem_wdata_o(memWdata[0]), .mem_rdata_i(memRdata[0]));

  mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(ARB_RR), .RD_LAT(2)) u_rr (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .mem_en_o(memEn[1]), .mem_we_o(memWe[1]),
    .mem_addr_o(memAddr[1]), .mem_wdata_o(memWdata[1]), .mem_rdata_i(memRdata[1]));

  function automatic logic [31:0] initWord(input int w);
    case (w)
      0:       return 32'h1111_1111;
      1:       return 32'h2222_2222;
      2:       return 32'h0000_0000;
      default: return {8'hC0, 8'(w), 16'h5A5A};
    endcase
  endfunction

  // Synchronous BRAMs: read-first, one extra output stage for the RD_LAT=2 side.
  logic [31:0] bram    [2][16];
  logic [31:0] rdStage [2][2];
  bit          loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int w = 0; w < 16; w++) begin
        bram[0][w] <= initWord(w);
        bram[1][w] <= initWord(w);
      end
      loaded <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (memEn[i]) begin
          if (memWe[i] == '0) begin
            rdStage[i][0] <= bram[i][memAddr[i][5:2]];
          end else begin
            for (int b = 0; b < BW; b++) begin
              if (memWe[i][b]) bram[i][memAddr[i][5:2]][8*b +: 8] <= memWdata[i][8*b +: 8];
            end
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) rdStage[i][1] <= rdStage[i][0];
  end

  assign memRdata[0] = rdStage[0][0];
  assign memRdata[1] = rdStage[1][1];

  // Reference model: grant rules, lock ownership and expected memory contents.
  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sbq0[$];
  exp_t        sbq1[$];
  int          ptr   [2];
  bit          lockV [2];
  int          lockO [2];
  logic [31:0] mdl   [2][16];
  int          cycleNo = 0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic int latOf(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic string tagOf(input int i);
    return (i == 0) ? "fixed" : "rr";
  endfunction

  function automatic logic [BW-1:0] beOf(input int j);
    return be[j*BW +: BW];
  endfunction

  function automatic logic [AW-1:0] addrOf(input int j);
    return addr[j*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wdataOf(input int j);
    return wdata[j*DW +: DW];
  endfunction

  function automatic void modelReset(input int i);
    ptr[i]   = 0;
    lockV[i] = 1'b0;
    lockO[i] = 0;
    if (i == 0) sbq0.delete(); else sbq1.delete();
  endfunction

  // Winner for this cycle, or -1 when nobody may be granted.
  function automatic int modelPick(input int i);
    int start;
    if (lockV[i]) return req[lockO[i]] ? lockO[i] : -1;
    start = (i == 1) ? ptr[i] : 0;
    for (int off = 0; off < N; off++) begin
      if (req[(start + off) % N]) return (start + off) % N;
    end
    return -1;
  endfunction

  function automatic void modelCommit(input int i, input int k);
    exp_t          e;
    int            w;
    logic [AW-1:0] a;
    logic [BW-1:0] bb;
    logic [DW-1:0] wd;
    if (rst) begin
      modelReset(i);
      return;
    end
    if (k >= 0) begin
      a  = addrOf(k);
      bb = beOf(k);
      wd = wdataOf(k);
      w  = int'(a[5:2]);
      if (bb == '0) begin
        e.id   = k;
        e.data = mdl[i][w];
        e.due  = cycleNo + latOf(i) - 1;
        if (i == 0) sbq0.push_back(e); else sbq1.push_back(e);
      end else begin
        for (int b = 0; b < BW; b++) if (bb[b]) mdl[i][w][8*b +: 8] = wd[8*b +: 8];
      end
      ptr[i] = (k + 1) % N;
    end
    if (lockV[i]) begin
      if (!lock[lockO[i]]) lockV[i] = 1'b0;
    end else if (k >= 0 && lock[k]) begin
      lockV[i] = 1'b1;
      lockO[i] = k;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, want %h", name, cycleNo, act, exp);
    end
  endtask

  task automatic checkOutput(input int i, input int k);
    logic [N-1:0] one;
    logic [N-1:0] expG;
    one  = 1;
    expG = (k >= 0) ? (one << k) : '0;
    check({tagOf(i), " gnt"},       gnt[i],      expG);
    check({tagOf(i), " mem_en"},    memEn[i],    (k >= 0));
    check({tagOf(i), " mem_we"},    memWe[i],    (k >= 0) ? beOf(k)    : '0);
    check({tagOf(i), " mem_addr"},  memAddr[i],  (k >= 0) ? addrOf(k)  : '0);
    check({tagOf(i), " mem_wdata"}, memWdata[i], (k >= 0) ? wdataOf(k) : '0);
  endtask

  // Monitor: each cycle the front scoreboard entry decides whether a return is due.
  task automatic monitorReturn(input int i);
    exp_t         e;
    bit           have;
    logic [N-1:0] one;
    logic [N-1:0] expR;
    one  = 1;
    have = 1'b0;
    expR = '0;
    if (i == 0 && sbq0.size() > 0) begin e = sbq0[0]; have = 1'b1; end
    if (i == 1 && sbq1.size() > 0) begin e = sbq1[0]; have = 1'b1; end
    if (have && e.due <= cycleNo) expR = one << e.id;
    check({tagOf(i), " rvalid"}, rvalid[i], expR);
    if (expR != '0) begin
      check({tagOf(i), " rdata"}, rdata[i], e.data);
      if (i == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) monitorReturn(i);
  end

  task automatic applyStimulus(input bit r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                               input logic [N*BW-1:0] b, input logic [N*AW-1:0] a,
                               input logic [N*DW-1:0] w);
    req   = rq;
    lock  = lk;
    be    = b;
    addr  = a;
    wdata = w;
    rst   = r;
    if (r) begin
      modelReset(0);
      modelReset(1);
    end
  endtask

  task automatic stepCycle();
    int k[2];
    for (int i = 0; i < 2; i++) k[i] = rst ? -1 : modelPick(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) checkOutput(i, k[i]);
    @(posedge clk);
    cycleNo++;
    for (int i = 0; i < 2; i++) modelCommit(i, k[i]);
    #1;
  endtask

  task automatic randomCycle(input bit r);
    logic [N-1:0]    rq;
    logic [N-1:0]    lk;
    logic [N*BW-1:0] b;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] w;
    for (int j = 0; j < N; j++) begin
      rq[j]          = ($urandom_range(0, 9) < 7);
      lk[j]          = ($urandom_range(0, 3) == 0);
      b[j*BW +: BW]  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      a[j*AW +: AW]  = $urandom & 32'hFFFF_FFFC;
      w[j*DW +: DW]  = $urandom;
    end
    applyStimulus(r, rq, lk, b, a, w);
    stepCycle();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      modelReset(i);
      for (int w = 0; w < 16; w++) mdl[i][w] = initWord(w);
    end

    // Reset: outputs forced low even with requests present.
    randomCycle(1'b1);
    randomCycle(1'b1);

    // Requester 0 writes DEADBEEF to 0x10, requester 1 reads it back.
    applyStimulus(1'b0, 3'b011, 3'b000, {4'h0, 4'h0, 4'hF},
                  {32'h0, 32'h10, 32'h10}, {32'h0, 32'h0, 32'hDEAD_BEEF});
    stepCycle();
    applyStimulus(1'b0, 3'b010, 3'b000, {4'h0, 4'h0, 4'hF},
                  {32'h0, 32'h10, 32'h10}, {32'h0, 32'h0, 32'hDEAD_BEEF});
    stepCycle();

    // Everyone requesting reads for six cycles.
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 3'b111, 3'b000, '0, {32'h8, 32'h4, 32'h0}, '0);
      stepCycle();
    end

    // Requester 1 takes the lock and keeps it for four grants.
    applyStimulus(1'b0, 3'b010, 3'b010, '0, {32'h0, 32'h4, 32'h0}, '0);
    stepCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 3'b011, 3'b010, '0, {32'h0, 32'h4, 32'h0}, '0);
      stepCycle();
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 3'b011, 3'b000, '0, {32'h0, 32'h4, 32'h0}, '0);
      stepCycle();
    end

    // Alternating reads of 0x0 and 0x4.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, (c % 2 == 0) ? 3'b001 : 3'b010, 3'b000, '0, {32'h0, 32'h4, 32'h0}, '0);
      stepCycle();
    end

    // Single-byte write into 0x8, then read it back.
    applyStimulus(1'b0, 3'b001, 3'b000, {4'h0, 4'h0, 4'b0100}, {32'h0, 32'h0, 32'h8}, {64'h0, 32'h00AB_0000});
    stepCycle();
    applyStimulus(1'b0, 3'b001, 3'b000, '0, {32'h0, 32'h0, 32'h8}, '0);
    stepCycle();
    applyStimulus(1'b0, 3'b000, 3'b000, '0, '0, '0);
    stepCycle();

    // Locked read in flight, then reset: nothing may return, lock is gone.
    applyStimulus(1'b0, 3'b010, 3'b010, '0, {32'h0, 32'h4, 32'h0}, '0);
    stepCycle();
    applyStimulus(1'b1, 3'b011, 3'b010, '0, {32'h0, 32'h4, 32'h0}, '0);
    stepCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 3'b011, 3'b000, '0, {32'h0, 32'h4, 32'h0}, '0);
      stepCycle();
    end

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      randomCycle((!rst) && ($urandom_range(0, 99) < 2));
    end

    // Drain outstanding reads.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 3'b000, 3'b000, '0, '0, '0);
      stepCycle();
    end
    check("fixed drain", sbq0.size(), 0);
    check("rr drain", sbq1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
